// File: rtl/aes_seq_pkg.sv
// Shared types and widths for the AES block sequencer and its output FIFO.
package aes_seq_pkg;
  localparam int AES_BLK_W = 128;
  localparam int BLK_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } seq_state_e;
endpackage

// File: rtl/aes_seq_out_fifo.sv
// Two-entry result FIFO with a combinational head; synchronous active-low reset.
module aes_seq_out_fifo
  import aes_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [AES_BLK_W-1:0] push_data,
  input  logic                 pop,
  output logic [1:0]           count,
  output logic [AES_BLK_W-1:0] head_data
);
  logic [AES_BLK_W-1:0] mem_reg [2];
  logic                 wr_ptr_reg;
  logic                 rd_ptr_reg;
  logic [1:0]           count_reg;
  logic                 do_push;
  logic                 do_pop;

  assign do_pop  = pop && (count_reg != 2'd0);
  // When full, a push is only legal if the head leaves in the same cycle.
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst) begin
        mem_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count     = count_reg;
  assign head_data = mem_reg[rd_ptr_reg];
endmodule

// File: rtl/aes_block_sequencer.sv
// Sequences one block at a time through an AES core (ld/done) and buffers results.
// Optional WAIT watchdog enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AES_BLK_W-1:0] key,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 core_ld,
  output logic [AES_BLK_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_text,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_text_out,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic                 err
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  seq_state_e           state_reg, state_next;
  logic [AES_BLK_W-1:0] key_reg;
  logic [AES_BLK_W-1:0] text_reg;
  logic [BLK_CNT_W-1:0] blk_cnt_reg;
  logic [1:0]           fifo_count;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 timeout_hit;

  // Admission only with a free slot guaranteed for the result; no path from out_ready.
  assign in_ready  = rst && (state_reg == IDLE) && (fifo_count <= 2'd1);
  assign accept    = in_valid && in_ready;
  assign push      = (state_reg == WAIT) && core_done;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] to_cnt_reg;
  logic       err_reg;

  // Abort on the WAIT cycle that would bring the counter to the limit; done wins.
  assign timeout_hit = (state_reg == WAIT) && !core_done && ((to_cnt_reg + 8'd1) == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_reg <= 8'd0;
      err_reg    <= 1'b0;
    end else begin
      to_cnt_reg <= (state_reg == WAIT) ? to_cnt_reg + 8'd1 : 8'd0;
      if (timeout_hit) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      key_reg     <= '0;
      text_reg    <= '0;
      blk_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        key_reg  <= key;
        text_reg <= in_data;
      end
      if (push) blk_cnt_reg <= blk_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    core_ld    = 1'b0;
    case (state_reg)
      IDLE: if (accept) state_next = LOAD;
      LOAD: begin
        core_ld    = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (core_done || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  aes_seq_out_fifo u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (core_text_out),
    .pop       (pop),
    .count     (fifo_count),
    .head_data (out_data)
  );

  assign core_key  = key_reg;
  assign core_text = text_reg;
  assign busy      = (state_reg != IDLE);
  assign blk_cnt   = blk_cnt_reg;
endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed + randomized bench for aes_block_sequencer with a fixed-latency AES core model.
module tb_aes_block_sequencer;
  import aes_seq_pkg::*;

  localparam int TO  = 16;
  localparam int LAT = 12;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic         core_done;
  logic [127:0] core_text_out;
  logic         busy;
  logic [15:0]  blk_cnt;
  logic         err;

  always #5 clk = ~clk;

  aes_block_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .key           (key),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .core_ld       (core_ld),
    .core_key      (core_key),
    .core_text     (core_text),
    .core_done     (core_done),
    .core_text_out (core_text_out),
    .busy          (busy),
    .blk_cnt       (blk_cnt),
    .err           (err)
  );

  // Stand-in cipher: the real FIPS-197 vector, otherwise a keyed scramble.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return t ^ {k[63:0], k[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
  endfunction

  // Core model: done exactly LAT cycles after ld, shares rst with the DUT.
  logic         mdl_done = 1'b0;
  logic         spur_done = 1'b0;
  logic         mute = 1'b0;
  logic [127:0] mdl_out = '0;
  logic [127:0] mdl_key = '0;
  logic [127:0] mdl_text = '0;
  int           mdl_cnt = 0;

  assign core_done     = mdl_done | spur_done;
  assign core_text_out = mdl_out;

  always @(posedge clk) begin
    if (!rst) begin
      mdl_cnt  <= 0;
      mdl_done <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (core_ld) begin
        mdl_cnt  <= LAT - 1;
        mdl_key  <= core_key;
        mdl_text <= core_text;
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1 && !mute) begin
          mdl_done <= 1'b1;
          mdl_out  <= aes_ref(mdl_key, mdl_text);
        end
      end
    end
  end

  int           n_checks = 0;
  int           n_fail = 0;
  int           exp_cnt = 0;
  bit           rand_ready = 1'b0;
  logic [127:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; any pop happening at this edge is checked against the reference queue.
  task automatic tick();
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) chk("pop_extra", out_valid, 1'b0);
      else chk("pop_data", out_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Returns in the cycle after the handshake edge (the LOAD cycle).
  task automatic send_block(input logic [127:0] k, input logic [127:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    key      = k;
    in_data  = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back(aes_ref(k, d));
        exp_cnt++;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", in_ready, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] ka, da, kb, db, kc, dc;
  int lat, ld_extra, nb;

  initial begin
    // Reset values
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_core_ld", core_ld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_blk_cnt", blk_cnt, 16'd0);
    chk("rst_core_key", core_key, '0);
    chk("rst_core_text", core_text, '0);
    chk("rst_out_data", out_data, '0);
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Single FIPS-197 block
    out_ready = 1'b0;
    send_block(FIPS_KEY, FIPS_PT);
    chk("ld_t1", core_ld, 1'b1);
    chk("core_key", core_key, FIPS_KEY);
    chk("core_text", core_text, FIPS_PT);
    tick();
    chk("ld_t2", core_ld, 1'b0);
    chk("busy_wait", busy, 1'b1);
    lat = 1;
    ld_extra = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
      if (core_ld) ld_extra++;
    end
    chk("result_latency", 128'(lat), 128'(LAT + 1));
    chk("ld_once", 128'(ld_extra), '0);
    chk("fips_out", out_data, FIPS_CT);
    chk("fips_blk_cnt", blk_cnt, 16'd1);
    chk("fips_idle", busy, 1'b0);
    chk("fips_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fips_drained", out_valid, 1'b0);

    // Spurious done in IDLE
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    chk("spur_blk_cnt", blk_cnt, 16'd1);
    chk("spur_no_push", out_valid, 1'b0);

    // Backpressure: two buffered, third held off until drain
    ka = rnd128(); da = rnd128(); kb = rnd128(); db = rnd128(); kc = rnd128(); dc = rnd128();
    send_block(ka, da);
    wait_idle();
    send_block(kb, db);
    wait_idle();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head", out_data, aes_ref(ka, da));
    in_valid = 1'b1; key = kc; in_data = dc;
    repeat (3) tick();
    chk("bp_hold_busy", busy, 1'b0);
    chk("bp_hold_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", in_ready, 1'b1);
    chk("bp_head2", out_data, aes_ref(kb, db));
    exp_q.push_back(aes_ref(kc, dc));
    exp_cnt++;
    tick();
    in_valid = 1'b0;
    chk("bp_ld_c", core_ld, 1'b1);
    chk("bp_empty", out_valid, 1'b0);
    wait_idle();
    tick();
    chk("bp_c_drained", out_valid, 1'b0);

    // Simultaneous push and pop with one entry buffered
    out_ready = 1'b0;
    ka = rnd128(); da = rnd128(); kb = rnd128(); db = rnd128();
    send_block(ka, da);
    wait_idle();
    send_block(kb, db);
    nb = 0;
    while (!core_done && nb < 100) begin
      tick();
      nb++;
    end
    chk("pp_done_seen", core_done, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_valid", out_valid, 1'b1);
    chk("pp_head", out_data, aes_ref(kb, db));
    chk("pp_count1", in_ready, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized traffic with random downstream stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_block(rnd128(), rnd128());
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 500 && (exp_q.size() != 0 || busy); i++) tick();
    chk("rand_drained", out_valid, 1'b0);
    chk("rand_blk_cnt", blk_cnt, 16'(exp_cnt));

    // Reset while in WAIT
    send_block(rnd128(), rnd128());
    repeat (4) tick();
    chk("rstw_busy_pre", busy, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_out_valid", out_valid, 1'b0);
    chk("rstw_blk_cnt", blk_cnt, 16'd0);
    chk("rstw_core_ld", core_ld, 1'b0);
    repeat (20) tick();
    chk("rstw_late_cnt", blk_cnt, 16'd0);
    chk("rstw_late_valid", out_valid, 1'b0);

`ifdef AES_SEQ_TIMEOUT_EN
    // Watchdog: core never answers
    mute = 1'b1;
    send_block(rnd128(), rnd128());
    nb = 1;
    while (busy && nb < 100) begin
      tick();
      nb++;
    end
    exp_q.delete();
    exp_cnt--;
    chk("to_busy_cycles", 128'(nb - 1), 128'(TO + 1));
    chk("to_err", err, 1'b1);
    chk("to_blk_cnt", blk_cnt, 16'(exp_cnt));
    chk("to_no_push", out_valid, 1'b0);
    mute = 1'b0;
    send_block(FIPS_KEY, FIPS_PT);
    wait_idle();
    chk("to_next_out", out_data, FIPS_CT);
    tick();
    chk("to_err_sticky", err, 1'b1);
    chk("to_next_cnt", blk_cnt, 16'(exp_cnt));
`else
    chk("err_tied", err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
